fpga_wr_arbiter: RTL and testbench
==================================

FPGA_WR_ARBITER -- requirements
Module: fpga_wr_arbiter

Parameters
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the width of the shared register bank.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, meaning the maximum writes per grant tenure (1..15).

Interface
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 Port clk_i SHALL be: input, 1 bit, clock, all state on the rising edge.
REQ-006 Port reset_i SHALL be: input, 1 bit, asynchronous active-high reset.
REQ-007 Port req_i SHALL be: input, NREQ bits, per-requester write request, level held until served.
REQ-008 Port data_i SHALL be: input, NREQ*WIDTH bits, per-requester write data; slice k is bits [k*WIDTH +: WIDTH].
REQ-009 Port gnt_o SHALL be: output, NREQ bits, registered one-hot grant, or all zero.
REQ-010 Port owner_o SHALL be: output, clog2(NREQ) bits, index of the granted requester, valid when busy_o=1.
REQ-011 Port busy_o SHALL be: output, 1 bit, high while any grant is held.
REQ-012 Port E_o SHALL be: output, 1 bit, clock enable to the shared enabled-DFF register bank.
REQ-013 Port D_o SHALL be: output, WIDTH bits, data to the shared register bank.

Function
REQ-014 The block SHALL implement states IDLE and GRANT; busy_o SHALL be 1 exactly in GRANT.
REQ-015 A rotating priority pointer ptr SHALL select, among asserted req_i bits, the first index at or after ptr, modulo NREQ.
REQ-016 In IDLE with any req_i high at a rising edge, the block SHALL enter GRANT at that edge with gnt_o one-hot on the selected index (1-cycle request-to-grant latency).
REQ-017 In IDLE, gnt_o SHALL be 0, E_o SHALL be 0 and D_o SHALL be 0.
REQ-018 In GRANT, E_o SHALL be combinational req_i[owner] AND busy_o, and D_o SHALL be data_i slice[owner] when E_o=1, else 0.
REQ-019 A burst counter SHALL clear on every new grant and increment on each cycle with E_o=1.
REQ-020 A tenure SHALL end at the edge where the owner's req_i is low, or where E_o=1 and the counter equals MAX_BURST-1.
REQ-021 At tenure end, ptr SHALL become (owner+1) mod NREQ, and arbitration SHALL be performed in the same edge using that new ptr, with no idle gap.
REQ-022 If tenure-end arbitration finds a request, the block SHALL stay in GRANT with the new owner (which may be the same requester if it alone requests); otherwise it SHALL go to IDLE.
REQ-023 gnt_o SHALL never have more than one bit set, and E_o SHALL never be 1 while gnt_o=0.
REQ-024 Changes to req_i bits of non-owners during a tenure SHALL have no effect until tenure end.
REQ-025 Requesters SHALL be served round-robin: no requester waits more than (NREQ-1)*MAX_BURST + NREQ cycles once its request is asserted.

Reset
REQ-026 On assertion of reset_i, the block SHALL immediately (asynchronously) force state to IDLE, gnt_o=0, owner_o=0, busy_o=0, E_o=0, D_o=0, ptr=0 and the burst counter to 0.
REQ-027 Reset asserted mid-tenure SHALL abort the tenure with no further E_o pulse.
REQ-028 After reset_i deasserts, arbitration SHALL begin at the first rising edge with reset_i low.

Verification
REQ-029 The bench SHALL cover reset: pulse reset_i with req_i=4'b1111 -> all outputs 0 during reset; first edge after release gives gnt_o=4'b0001, owner_o=0.
REQ-030 The bench SHALL cover single requester: req_i=4'b0100 held, data_i slice2=8'hA5 -> gnt_o=4'b0100 after 1 edge; E_o=1 and D_o=8'hA5 for exactly 4 cycles; then re-granted to the same requester with no gap.
REQ-031 The bench SHALL cover round-robin: req_i=4'b1111 held -> owners 0,1,2,3,0, each with 4 E_o cycles, and back-to-back grants.
REQ-032 The bench SHALL cover early release: owner 1 drops req after 2 writes while req_i[3]=1 -> at that edge gnt_o=4'b1000 and ptr=2; the burst counter restarts.
REQ-033 The bench SHALL cover reset mid-burst: assert reset_i after 2 writes of owner 0 -> E_o drops to 0 immediately, and ptr=0 after release.
REQ-034 The bench SHALL cover the final drop: all req_i fall while owner 3 is granted -> the next edge gives IDLE, gnt_o=0, busy_o=0, ptr=0.

Source files
------------

// File: rtl/fpga_wr_arbiter_if.sv
// rtl/fpga_wr_arbiter_if.sv - requester/arbiter bundle for the shared register bank write arbiter
interface fpga_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_i;
    logic [NREQ*WIDTH-1:0] data_i;
    logic [NREQ-1:0]       gnt_o;
    logic [IW-1:0]         owner_o;
    logic                  busy_o;
    logic                  E_o;
    logic [WIDTH-1:0]      D_o;

    modport master (
        output req_i, data_i,
        input  gnt_o, owner_o, busy_o, E_o, D_o
    );

    modport slave (
        input  req_i, data_i,
        output gnt_o, owner_o, busy_o, E_o, D_o
    );
endinterface

// File: rtl/fpga_wr_arbiter.sv
// rtl/fpga_wr_arbiter.sv - round-robin write arbiter with bounded bursts onto a shared enabled-DFF bank
module fpga_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    fpga_wr_arbiter_if.slave   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]      state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   nxt_ptr;
    logic [IW-1:0]   base;
    logic [IW-1:0]   sel;
    logic            found;
    logic [3:0]      burst_cnt;
    logic [NREQ-1:0] gnt;
    logic            e;
    logic            tenure_end;

    assign nxt_ptr = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

    // Tenure-end arbitration already uses the advanced pointer so the hand-off has no idle cycle.
    assign base = (state == GRANT) ? nxt_ptr : ptr;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = int'(base) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req_i[j]) begin
                sel   = IW'(j);
                found = 1'b1;
            end
        end
    end

    assign e          = (state == GRANT) && bus.req_i[owner];
    assign tenure_end = (state == GRANT) &&
                        (!bus.req_i[owner] || (burst_cnt == 4'(MAX_BURST - 1)));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
            gnt       <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                state     <= GRANT;
                owner     <= sel;
                gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << sel;
                burst_cnt <= '0;
            end
        end else if (tenure_end) begin
            ptr <= nxt_ptr;
            if (found) begin
                owner     <= sel;
                gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << sel;
                burst_cnt <= '0;
            end else begin
                state     <= IDLE;
                gnt       <= '0;
                burst_cnt <= '0;
            end
        end else if (e) begin
            burst_cnt <= burst_cnt + 4'd1;
        end
    end

    assign bus.gnt_o   = gnt;
    assign bus.owner_o = owner;
    assign bus.busy_o  = (state == GRANT);
    assign bus.E_o     = e;
    assign bus.D_o     = e ? bus.data_i[owner*WIDTH +: WIDTH] : '0;
endmodule

// File: tb/tb_fpga_wr_arbiter.sv
// tb/tb_fpga_wr_arbiter.sv - directed self-checking bench for fpga_wr_arbiter
module tb_fpga_wr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    fpga_wr_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

    fpga_wr_arbiter #(.NREQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] slice_val [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("onehot0_gnt", 32'($onehot0(bus.gnt_o)), 32'd1);
        check("E_without_gnt", 32'(bus.E_o && (bus.gnt_o == 4'b0000)), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_data();
        bus.data_i = {slice_val[3], slice_val[2], slice_val[1], slice_val[0]};
    endtask

    initial begin
        slice_val[0] = 8'h11;
        slice_val[1] = 8'h22;
        slice_val[2] = 8'hA5;
        slice_val[3] = 8'h44;
        bus.req_i = 4'b1111;
        set_data();

        // reset with all requesting
        #1;
        rst = 1'b1;
        #1;
        check("rst_gnt", 32'(bus.gnt_o), 32'h0);
        check("rst_owner", 32'(bus.owner_o), 32'h0);
        check("rst_busy", 32'(bus.busy_o), 32'h0);
        check("rst_E", 32'(bus.E_o), 32'h0);
        check("rst_D", 32'(bus.D_o), 32'h0);
        @(posedge clk);
        #1;
        check("rst_held_gnt", 32'(bus.gnt_o), 32'h0);
        check("rst_held_busy", 32'(bus.busy_o), 32'h0);
        rst = 1'b0;
        tick();
        check("rel_gnt", 32'(bus.gnt_o), 32'h1);
        check("rel_owner", 32'(bus.owner_o), 32'h0);
        check("rel_busy", 32'(bus.busy_o), 32'h1);

        // single requester, burst of 4 then immediate re-grant
        do_reset();
        bus.req_i = 4'b0100;
        tick();
        check("single_gnt", 32'(bus.gnt_o), 32'h4);
        check("single_owner", 32'(bus.owner_o), 32'h2);
        for (int i = 0; i < 4; i++) begin
            check("single_E", 32'(bus.E_o), 32'h1);
            check("single_D", 32'(bus.D_o), 32'hA5);
            tick();
        end
        check("single_regnt", 32'(bus.gnt_o), 32'h4);
        check("single_regnt_busy", 32'(bus.busy_o), 32'h1);
        check("single_regnt_E", 32'(bus.E_o), 32'h1);
        check("single_ptr", 32'(dut.ptr), 32'h3);
        check("single_cnt", 32'(dut.burst_cnt), 32'h0);

        // round robin with everyone requesting
        do_reset();
        bus.req_i = 4'b1111;
        tick();
        for (int t = 0; t < 5; t++) begin
            int k;
            k = t % 4;
            for (int c = 0; c < 4; c++) begin
                check("rr_owner", 32'(bus.owner_o), 32'(k));
                check("rr_gnt", 32'(bus.gnt_o), 32'(1 << k));
                check("rr_E", 32'(bus.E_o), 32'h1);
                check("rr_D", 32'(bus.D_o), 32'(slice_val[k]));
                tick();
            end
        end
        check("rr_after_owner", 32'(bus.owner_o), 32'h1);

        // early release by owner 1 hands off to 3
        do_reset();
        bus.req_i = 4'b1010;
        tick();
        check("early_owner", 32'(bus.owner_o), 32'h1);
        tick();
        tick();
        check("early_cnt2", 32'(dut.burst_cnt), 32'h2);
        bus.req_i = 4'b1000;
        #1;
        check("early_E_drop", 32'(bus.E_o), 32'h0);
        check("early_D_drop", 32'(bus.D_o), 32'h0);
        tick();
        check("early_gnt", 32'(bus.gnt_o), 32'h8);
        check("early_ptr", 32'(dut.ptr), 32'h2);
        check("early_cnt0", 32'(dut.burst_cnt), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("early_E3", 32'(bus.E_o), 32'h1);
            check("early_D3", 32'(bus.D_o), 32'h44);
            tick();
        end
        check("early_ptr_after", 32'(dut.ptr), 32'h0);

        // reset in the middle of a burst
        do_reset();
        bus.req_i = 4'b0001;
        tick();
        tick();
        tick();
        check("mid_pre_E", 32'(bus.E_o), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_E", 32'(bus.E_o), 32'h0);
        check("mid_D", 32'(bus.D_o), 32'h0);
        check("mid_gnt", 32'(bus.gnt_o), 32'h0);
        check("mid_busy", 32'(bus.busy_o), 32'h0);
        @(posedge clk);
        #1;
        check("mid_held_E", 32'(bus.E_o), 32'h0);
        rst = 1'b0;
        check("mid_ptr", 32'(dut.ptr), 32'h0);
        tick();
        check("mid_regnt", 32'(bus.gnt_o), 32'h1);

        // last owner 3 drops with nobody else requesting
        do_reset();
        bus.req_i = 4'b0100;
        tick();
        bus.req_i = 4'b1000;
        tick();
        check("drop_owner3", 32'(bus.owner_o), 32'h3);
        check("drop_ptr3", 32'(dut.ptr), 32'h3);
        bus.req_i = 4'b0000;
        tick();
        check("drop_gnt", 32'(bus.gnt_o), 32'h0);
        check("drop_busy", 32'(bus.busy_o), 32'h0);
        check("drop_E", 32'(bus.E_o), 32'h0);
        check("drop_D", 32'(bus.D_o), 32'h0);
        check("drop_ptr", 32'(dut.ptr), 32'h0);
        tick();
        check("idle_stays", 32'(bus.busy_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
